// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: EXE command encodings, NZCV bit positions
// and the id-width helper.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // A single requester still needs a one-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU-side and response signals around the shared-ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid is high and ready is low.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32,
    parameter int IDW     = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_in1;
    logic [NUM_REQ*DW-1:0] req_in2;
    logic [NUM_REQ*4-1:0]  req_cmd;
    logic [NUM_REQ-1:0]    req_s;
    logic                  flush;

    logic [DW-1:0]         alu_in1;
    logic [DW-1:0]         alu_in2;
    logic [3:0]            alu_cmd;
    logic                  alu_c_in;
    logic [DW-1:0]         alu_result;
    logic                  alu_n;
    logic                  alu_z;
    logic                  alu_c;
    logic                  alu_v;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_result;
    logic [3:0]            rsp_flags;
    logic [3:0]            sr_flags;
    logic [IDW-1:0]        dbg_ptr;

    modport master (
        output req_valid, req_in1, req_in2, req_cmd, req_s, flush,
        output alu_result, alu_n, alu_z, alu_c, alu_v, rsp_ready,
        input  req_ready, alu_in1, alu_in2, alu_cmd, alu_c_in,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, sr_flags, dbg_ptr
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_cmd, req_s, flush,
        input  alu_result, alu_n, alu_z, alu_c, alu_v, rsp_ready,
        output req_ready, alu_in1, alu_in2, alu_cmd, alu_c_in,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, sr_flags, dbg_ptr
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin finder: first valid index at or after ptr, wrapping.
module alu_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     winner_o,
    output logic               found_o
);

    int idx;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_o && valid_i[idx]) begin
                found_o  = 1'b1;
                winner_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU; owns the NZCV
// register and a single registered response slot tagged with the requester id.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    logic [IDW-1:0] winner;
    logic           found;
    logic           can_accept;
    logic           accept;
    logic [3:0]     alu_flags;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_result_q, rsp_result_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;
    logic [3:0]     sr_q, sr_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    alu_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid_i  (bus.req_valid),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    // The slot may refill on the same edge it is consumed; flush blocks any accept.
    assign can_accept = !bus.flush && (!rsp_valid_q || bus.rsp_ready);
    assign accept     = found && can_accept && rst;

    assign bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        bus.alu_cmd = '0;
        if (found) begin
            bus.alu_in1 = bus.req_in1[int'(winner)*DW +: DW];
            bus.alu_in2 = bus.req_in2[int'(winner)*DW +: DW];
            bus.alu_cmd = bus.req_cmd[int'(winner)*4 +: 4];
        end
    end

    assign bus.alu_c_in = sr_q[FLAG_C];

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = bus.alu_n;
        alu_flags[FLAG_Z] = bus.alu_z;
        alu_flags[FLAG_C] = bus.alu_c;
        alu_flags[FLAG_V] = bus.alu_v;
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        sr_d         = sr_q;
        ptr_d        = ptr_q;
        if (bus.flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = winner;
            rsp_result_d = bus.alu_result;
            rsp_flags_d  = alu_flags;
            ptr_d        = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            if (bus.req_s[winner]) begin
                sr_d = alu_flags;
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            sr_q         <= '0;
            ptr_q        <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            sr_q         <= sr_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.sr_flags   = sr_q;
    assign bus.dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a behavioural ALU beside it.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_arbiter_if #(.NUM_REQ(2), .DW(DW)) bus ();

    alu_arbiter #(.NUM_REQ(2), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external ALU model ----------------
    logic [DW:0]   alu_t;
    logic [DW-1:0] alu_b;
    logic          alu_arith;

    always_comb begin
        alu_t     = '0;
        alu_b     = bus.alu_in2;
        alu_arith = 1'b0;
        case (bus.alu_cmd)
            CMD_MOV: alu_t = {1'b0, bus.alu_in2};
            CMD_MVN: alu_t = {1'b0, ~bus.alu_in2};
            CMD_ADD: begin
                alu_arith = 1'b1;
                alu_t = {1'b0, bus.alu_in1} + {1'b0, alu_b};
            end
            CMD_ADC: begin
                alu_arith = 1'b1;
                alu_t = {1'b0, bus.alu_in1} + {1'b0, alu_b} + {{DW{1'b0}}, bus.alu_c_in};
            end
            CMD_SUB: begin
                alu_arith = 1'b1;
                alu_b = ~bus.alu_in2;
                alu_t = {1'b0, bus.alu_in1} + {1'b0, alu_b} + {{DW{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                alu_arith = 1'b1;
                alu_b = ~bus.alu_in2;
                alu_t = {1'b0, bus.alu_in1} + {1'b0, alu_b} + {{DW{1'b0}}, bus.alu_c_in};
            end
            CMD_AND: alu_t = {1'b0, bus.alu_in1 & bus.alu_in2};
            CMD_ORR: alu_t = {1'b0, bus.alu_in1 | bus.alu_in2};
            CMD_EOR: alu_t = {1'b0, bus.alu_in1 ^ bus.alu_in2};
            default: alu_t = '0;
        endcase
    end

    assign bus.alu_result = alu_t[DW-1:0];
    assign bus.alu_n = alu_t[DW-1];
    assign bus.alu_z = (alu_t[DW-1:0] == '0);
    assign bus.alu_c = alu_arith & alu_t[DW];
    assign bus.alu_v = alu_arith & (bus.alu_in1[DW-1] == alu_b[DW-1]) &
                       (alu_t[DW-1] != bus.alu_in1[DW-1]);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy, input logic fl, input logic [1:0] s,
                         input logic [3:0] c0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [3:0] c1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        bus.req_valid = v;
        bus.rsp_ready = rdy;
        bus.flush     = fl;
        bus.req_s     = s;
        bus.req_cmd   = {c1, c0};
        bus.req_in1   = {a1, a0};
        bus.req_in2   = {b1, b0};
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]    v;
        logic          rdy;
        logic          fl;
        logic [1:0]    s;
        logic [3:0]    c0;
        logic [DW-1:0] a0, b0;
        logic [3:0]    c1;
        logic [DW-1:0] a1, b1;
        logic [1:0]    e_ready;
        logic          e_cin;
        logic          e_rv;
        logic          e_id;
        logic [DW-1:0] e_res;
        logic [3:0]    e_fl;
        logic [3:0]    e_sr;
        logic          e_ptr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic [1:0] v, logic rdy, logic fl, logic [1:0] s,
        logic [3:0] c0, logic [DW-1:0] a0, logic [DW-1:0] b0,
        logic [3:0] c1, logic [DW-1:0] a1, logic [DW-1:0] b1,
        logic [1:0] e_ready, logic e_cin, logic e_rv, logic e_id,
        logic [DW-1:0] e_res, logic [3:0] e_fl, logic [3:0] e_sr, logic e_ptr);
        vec_t r;
        r.v = v; r.rdy = rdy; r.fl = fl; r.s = s;
        r.c0 = c0; r.a0 = a0; r.b0 = b0; r.c1 = c1; r.a1 = a1; r.b1 = b1;
        r.e_ready = e_ready; r.e_cin = e_cin; r.e_rv = e_rv; r.e_id = e_id;
        r.e_res = e_res; r.e_fl = e_fl; r.e_sr = e_sr; r.e_ptr = e_ptr;
        return r;
    endfunction

    logic [DW:0] exp_q[$];
    logic [DW:0] exp_item;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 2'b00, CMD_ADD, 3, 4, CMD_ADD, 5, 6);

        //   v     rdy fl  s      c0       a0            b0   c1       a1    b1      rdy  cin rv id res           flags    sr       ptr
        vecs.push_back(mk(2'b01, 1, 0, 2'b00, CMD_ADD, 3,  4, CMD_NOP, 0,    0,    2'b01, 0, 1, 0, 32'h7,        4'b0000, 4'b0000, 1));
        vecs.push_back(mk(2'b00, 1, 0, 2'b00, CMD_NOP, 0,  0, CMD_NOP, 0,    0,    2'b00, 0, 0, 0, 32'h7,        4'b0000, 4'b0000, 1));
        vecs.push_back(mk(2'b01, 1, 0, 2'b01, CMD_SUB, 5,  5, CMD_NOP, 0,    0,    2'b01, 0, 1, 0, 32'h0,        4'b0110, 4'b0110, 1));
        vecs.push_back(mk(2'b01, 1, 0, 2'b00, CMD_MOV, 0,  1, CMD_NOP, 0,    0,    2'b01, 1, 1, 0, 32'h1,        4'b0000, 4'b0110, 1));
        vecs.push_back(mk(2'b01, 1, 0, 2'b00, CMD_ADC, 1,  1, CMD_NOP, 0,    0,    2'b01, 1, 1, 0, 32'h3,        4'b0000, 4'b0110, 1));
        vecs.push_back(mk(2'b10, 1, 0, 2'b10, CMD_NOP, 0,  0, CMD_ADD, 32'h7FFFFFFF, 1, 2'b10, 1, 1, 1, 32'h80000000, 4'b1001, 4'b1001, 0));
        vecs.push_back(mk(2'b11, 1, 0, 2'b01, CMD_SBC, 10, 3, CMD_EOR, 32'hF0, 32'hFF, 2'b01, 0, 1, 0, 32'h6,   4'b0010, 4'b0010, 1));
        vecs.push_back(mk(2'b11, 1, 0, 2'b01, CMD_SBC, 10, 3, CMD_EOR, 32'hF0, 32'hFF, 2'b10, 1, 1, 1, 32'h0F,  4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'b01, 0, 1, 2'b01, CMD_ADD, 3,  4, CMD_NOP, 0,    0,    2'b00, 1, 0, 1, 32'h0F,       4'b0000, 4'b0010, 0));
        vecs.push_back(mk(2'b01, 0, 0, 2'b00, CMD_ADD, 3,  4, CMD_NOP, 0,    0,    2'b01, 1, 1, 0, 32'h7,        4'b0000, 4'b0010, 1));
        vecs.push_back(mk(2'b01, 0, 0, 2'b00, CMD_ADD, 8,  8, CMD_NOP, 0,    0,    2'b00, 1, 1, 0, 32'h7,        4'b0000, 4'b0010, 1));
        vecs.push_back(mk(2'b00, 1, 0, 2'b00, CMD_NOP, 0,  0, CMD_NOP, 0,    0,    2'b00, 1, 0, 0, 32'h7,        4'b0000, 4'b0010, 1));

        // Reset state, with both requesters valid to show ready is held low.
        #7;
        chk("reset_ready", 64'(bus.req_ready), 64'h0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'h0);
        chk("reset_rsp_result", 64'(bus.rsp_result), 64'h0);
        chk("reset_rsp_flags", 64'(bus.rsp_flags), 64'h0);
        chk("reset_sr", 64'(bus.sr_flags), 64'h0);
        chk("reset_ptr", 64'(bus.dbg_ptr), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rdy, vecs[i].fl, vecs[i].s, vecs[i].c0, vecs[i].a0, vecs[i].b0,
                  vecs[i].c1, vecs[i].a1, vecs[i].b1);
            #1;
            chk($sformatf("row%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
            chk($sformatf("row%0d_alu_c_in", i), 64'(bus.alu_c_in), 64'(vecs[i].e_cin));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_rv));
            chk($sformatf("row%0d_rsp_id", i), 64'(bus.rsp_id), 64'(vecs[i].e_id));
            chk($sformatf("row%0d_rsp_result", i), 64'(bus.rsp_result), 64'(vecs[i].e_res));
            chk($sformatf("row%0d_rsp_flags", i), 64'(bus.rsp_flags), 64'(vecs[i].e_fl));
            chk($sformatf("row%0d_sr_flags", i), 64'(bus.sr_flags), 64'(vecs[i].e_sr));
            chk($sformatf("row%0d_ptr", i), 64'(bus.dbg_ptr), 64'(vecs[i].e_ptr));
        end

        // Contention after a fresh reset: strict alternation starting at requester 0.
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back((i % 2 == 0) ? {1'b0, 32'hA} : {1'b1, 32'hB});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(2'b11, 1'b1, 1'b0, 2'b00, CMD_MOV, 0, 32'hA, CMD_MOV, 0, 32'hB);
            #1;
            chk($sformatf("cont%0d_req_ready", i), 64'(bus.req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            @(posedge clk);
            #1;
            exp_item = exp_q.pop_front();
            chk($sformatf("cont%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'h1);
            chk($sformatf("cont%0d_rsp", i), 64'({bus.rsp_id, bus.rsp_result}), 64'(exp_item));
        end

        // Backpressure: slot holds id1/0xB for three cycles while req1 waits.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b10, 1'b0, 1'b0, 2'b00, CMD_NOP, 0, 0, CMD_ADD, 2, 2);
            #1;
            chk($sformatf("bp%0d_req_ready", i), 64'(bus.req_ready), 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_rsp", i), 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_result}), {31'h0, 1'b1, 1'b1, 32'hB});
            chk($sformatf("bp%0d_ptr", i), 64'(bus.dbg_ptr), 64'h0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(bus.req_ready), 64'h2);
        @(posedge clk);
        #1;
        chk("bp_release_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_result}), {31'h0, 1'b1, 1'b1, 32'h4});

        // Load Z into SR, leave the slot full, then reset between clock edges.
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 2'b01, CMD_MOV, 0, 0, CMD_NOP, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_sr", 64'(bus.sr_flags), 64'h4);
        chk("pre_reset_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("pre_reset_ptr", 64'(bus.dbg_ptr), 64'h1);
        @(negedge clk);
        drive(2'b11, 1'b1, 1'b0, 2'b00, CMD_MOV, 0, 32'h55, CMD_MOV, 0, 32'h66);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("async_rst_sr", 64'(bus.sr_flags), 64'h0);
        chk("async_rst_rsp_result", 64'(bus.rsp_result), 64'h0);
        chk("async_rst_ptr", 64'(bus.dbg_ptr), 64'h0);
        chk("async_rst_req_ready", 64'(bus.req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("post_rst_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_result}), {31'h0, 1'b1, 1'b0, 32'h55});

        @(negedge clk);
        drive(2'b00, 1'b1, 1'b0, 2'b00, CMD_NOP, 0, 0, CMD_NOP, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
